// File: rtl/classify_score_if.sv
// Sample/result bus for classify_score: activation handshake, scored result,
// run counters and the confusion-matrix read port.
interface classify_score_if #(
    parameter int unsigned ACT_W = 32,
    parameter int unsigned CNT_W = 32
);
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACT_W-1:0] act_n0;
    logic signed [ACT_W-1:0] act_n1;
    logic signed [ACT_W-1:0] act_n2;
    logic signed [ACT_W-1:0] act_n3;
    logic [3:0]              label;
    logic [1:0]              pred_class;
    logic                    pred_valid;
    logic                    correct;
    logic [CNT_W-1:0]        sample_count;
    logic [CNT_W-1:0]        error_counter;
    logic                    done;
    logic [3:0]              cm_rd_addr;
    logic [15:0]             cm_rd_data;

    modport master (
        output clear, in_valid, act_n0, act_n1, act_n2, act_n3, label, cm_rd_addr,
        input  in_ready, pred_class, pred_valid, correct, sample_count, error_counter,
               done, cm_rd_data
    );

    modport slave (
        input  clear, in_valid, act_n0, act_n1, act_n2, act_n3, label, cm_rd_addr,
        output in_ready, pred_class, pred_valid, correct, sample_count, error_counter,
               done, cm_rd_data
    );
endinterface

// File: rtl/classify_score.sv
// classify_score: sequential argmax over four signed activations, label
// comparison, saturating sample/error counters and a done flag after
// NUM_SAMPLES samples.
// Optional feature macro: CLASSIFY_CONFUSION_EN (4x4 confusion matrix of
// saturating 16-bit cells, read through cm_rd_addr/cm_rd_data).
module classify_score #(
    parameter int unsigned ACT_W       = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned NUM_SAMPLES = 10
) (
    input  logic            clk,
    input  logic            reset,
    classify_score_if.slave sb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ACT_W-1:0] act1_q, act1_d;
    logic signed [ACT_W-1:0] act2_q, act2_d;
    logic signed [ACT_W-1:0] act3_q, act3_d;
    logic [3:0]              label_q, label_d;
    logic [1:0]              scan_k_q, scan_k_d;
    logic [1:0]              best_idx_q, best_idx_d;
    logic signed [ACT_W-1:0] best_val_q, best_val_d;
    logic [1:0]              pred_class_q, pred_class_d;
    logic                    pred_valid_q, pred_valid_d;
    logic                    correct_q, correct_d;
    logic [CNT_W-1:0]        sample_count_q, sample_count_d;
    logic [CNT_W-1:0]        error_counter_q, error_counter_d;
    logic                    done_q, done_d;
    logic signed [ACT_W-1:0] scan_val_c;
    logic                    cm_inc_c;
    logic                    in_ready_c;

    // Accept only while idle; a same-cycle clear takes priority over in_valid.
    assign in_ready_c = (state_q == IDLE) && !sb.clear;

    assign sb.in_ready      = in_ready_c;
    assign sb.pred_class    = pred_class_q;
    assign sb.pred_valid    = pred_valid_q;
    assign sb.correct       = correct_q;
    assign sb.sample_count  = sample_count_q;
    assign sb.error_counter = error_counter_q;
    assign sb.done          = done_q;

    // Activation under comparison in the current scan step.
    always_comb begin
        case (scan_k_q)
            2'd1:    scan_val_c = act1_q;
            2'd2:    scan_val_c = act2_q;
            default: scan_val_c = act3_q;
        endcase
    end

    // Next-state, argmax datapath and counter update.
    always_comb begin
        state_d         = state_q;
        act1_d          = act1_q;
        act2_d          = act2_q;
        act3_d          = act3_q;
        label_d         = label_q;
        scan_k_d        = scan_k_q;
        best_idx_d      = best_idx_q;
        best_val_d      = best_val_q;
        pred_class_d    = pred_class_q;
        pred_valid_d    = 1'b0;
        correct_d       = correct_q;
        sample_count_d  = sample_count_q;
        error_counter_d = error_counter_q;
        done_d          = done_q;
        cm_inc_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (sb.in_valid && in_ready_c) begin
                    act1_d     = sb.act_n1;
                    act2_d     = sb.act_n2;
                    act3_d     = sb.act_n3;
                    label_d    = sb.label;
                    best_idx_d = 2'd0;
                    best_val_d = sb.act_n0;
                    scan_k_d   = 2'd1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Strictly greater only, so ties keep the lower index.
                if (scan_val_c > best_val_q) begin
                    best_idx_d = scan_k_q;
                    best_val_d = scan_val_c;
                end
                if (scan_k_q == 2'd3) begin
                    state_d      = RESULT;
                    pred_valid_d = 1'b1;
                    pred_class_d = best_idx_d;
                    correct_d    = (label_q[3:2] == 2'b00) && (best_idx_d == label_q[1:0]);
                end else begin
                    scan_k_d = scan_k_q + 2'd1;
                end
            end
            RESULT: begin
                if (sample_count_q != {CNT_W{1'b1}}) begin
                    sample_count_d = sample_count_q + CNT_W'(1);
                end
                if (!correct_q && (error_counter_q != {CNT_W{1'b1}})) begin
                    error_counter_d = error_counter_q + CNT_W'(1);
                end
                cm_inc_c = (label_q[3:2] == 2'b00);
                if (sample_count_d == CNT_W'(NUM_SAMPLES)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear aborts any sample in flight and restarts the run.
        if (sb.clear) begin
            state_d         = IDLE;
            pred_valid_d    = 1'b0;
            sample_count_d  = '0;
            error_counter_d = '0;
            done_d          = 1'b0;
            cm_inc_c        = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            act1_q          <= '0;
            act2_q          <= '0;
            act3_q          <= '0;
            label_q         <= '0;
            scan_k_q        <= '0;
            best_idx_q      <= '0;
            best_val_q      <= '0;
            pred_class_q    <= '0;
            pred_valid_q    <= 1'b0;
            correct_q       <= 1'b0;
            sample_count_q  <= '0;
            error_counter_q <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            act1_q          <= act1_d;
            act2_q          <= act2_d;
            act3_q          <= act3_d;
            label_q         <= label_d;
            scan_k_q        <= scan_k_d;
            best_idx_q      <= best_idx_d;
            best_val_q      <= best_val_d;
            pred_class_q    <= pred_class_d;
            pred_valid_q    <= pred_valid_d;
            correct_q       <= correct_d;
            sample_count_q  <= sample_count_d;
            error_counter_q <= error_counter_d;
            done_q          <= done_d;
        end
    end

`ifdef CLASSIFY_CONFUSION_EN
    logic [15:0] cm_q [16];
    logic [3:0]  cm_idx_c;

    assign cm_idx_c      = {label_q[1:0], pred_class_q};
    assign sb.cm_rd_data = cm_q[sb.cm_rd_addr];

    // Confusion cells: cleared with the counters, saturating increment per scored sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) cm_q[i] <= '0;
        end else if (sb.clear) begin
            for (int i = 0; i < 16; i++) cm_q[i] <= '0;
        end else if (cm_inc_c && (cm_q[cm_idx_c] != 16'hFFFF)) begin
            cm_q[cm_idx_c] <= cm_q[cm_idx_c] + 16'd1;
        end
    end
`else
    logic unused_cm;

    assign unused_cm     = ^{cm_inc_c, sb.cm_rd_addr};
    assign sb.cm_rd_data = 16'd0;
`endif

endmodule

// File: tb/tb_classify_score.sv
// Directed bench for classify_score, built with NUM_SAMPLES=4 so a short run
// reaches done.
module tb_classify_score;

    localparam int unsigned ACT_W = 32;
    localparam int unsigned CNT_W = 32;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    classify_score_if #(.ACT_W(ACT_W), .CNT_W(CNT_W)) sb ();

    classify_score #(
        .ACT_W      (ACT_W),
        .CNT_W      (CNT_W),
        .NUM_SAMPLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one sample and return just after the accepting edge.
    task automatic send(input logic signed [ACT_W-1:0] a0, input logic signed [ACT_W-1:0] a1,
                        input logic signed [ACT_W-1:0] a2, input logic signed [ACT_W-1:0] a3,
                        input logic [3:0] lbl);
        int w;
        w = 0;
        while (!sb.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout: in_ready=%b required 1", sb.in_ready);
        end
        sb.act_n0   = a0;
        sb.act_n1   = a1;
        sb.act_n2   = a2;
        sb.act_n3   = a3;
        sb.label    = lbl;
        sb.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.in_valid = 1'b0;
    endtask

    // Watch n falling edges; record pred_valid pulses and the held result.
    task automatic observe(input int n, output int pulses, output int first_at,
                           output logic [1:0] pc, output logic cor, output logic rdy_last);
        pulses   = 0;
        first_at = 0;
        pc       = 2'd0;
        cor      = 1'b0;
        rdy_last = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (sb.pred_valid === 1'b1) begin
                pulses++;
                if (first_at == 0) first_at = i;
                pc  = sb.pred_class;
                cor = sb.correct;
            end
            rdy_last = sb.in_ready;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        sb.clear    = 1'b0;
        sb.in_valid = 1'b0;
        sb.act_n0   = '0;
        sb.act_n1   = '0;
        sb.act_n2   = '0;
        sb.act_n3   = '0;
        sb.label    = '0;
        sb.cm_rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sb.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", sb.in_ready); end
        checks++;
        if (sb.pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid: got %b required 0", sb.pred_valid); end
        checks++;
        if (sb.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", sb.done); end
        checks++;
        if (sb.sample_count !== 32'd0) begin errors++; $display("FAIL reset_sample_count: got %0d required 0", sb.sample_count); end
        checks++;
        if (sb.error_counter !== 32'd0) begin errors++; $display("FAIL reset_error_counter: got %0d required 0", sb.error_counter); end
        checks++;
        if (sb.pred_class !== 2'd0 || sb.correct !== 1'b0) begin
            errors++; $display("FAIL reset_result: pred_class=%0d correct=%b required 0/0", sb.pred_class, sb.correct);
        end
    endtask

    // Generic scored-sample scenario used by the per-feature tests.
    task automatic test_sample(input string name,
                               input logic signed [ACT_W-1:0] a0, input logic signed [ACT_W-1:0] a1,
                               input logic signed [ACT_W-1:0] a2, input logic signed [ACT_W-1:0] a3,
                               input logic [3:0] lbl, input logic [1:0] exp_pc, input logic exp_cor,
                               input int exp_cnt, input int exp_err, input logic exp_rdy);
        int pulses, first_at;
        logic [1:0] pc;
        logic cor, rdy;
        send(a0, a1, a2, a3, lbl);
        observe(5, pulses, first_at, pc, cor, rdy);
        checks++;
        if (pulses != 1 || first_at != 4) begin
            errors++; $display("FAIL %s_pulse: pulses=%0d at=%0d required 1 at 4", name, pulses, first_at);
        end
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL %s_pred_class: got %0d required %0d", name, pc, exp_pc); end
        checks++;
        if (cor !== exp_cor) begin errors++; $display("FAIL %s_correct: got %b required %b", name, cor, exp_cor); end
        checks++;
        if (sb.sample_count !== 32'(exp_cnt)) begin
            errors++; $display("FAIL %s_sample_count: got %0d required %0d", name, sb.sample_count, exp_cnt);
        end
        checks++;
        if (sb.error_counter !== 32'(exp_err)) begin
            errors++; $display("FAIL %s_error_counter: got %0d required %0d", name, sb.error_counter, exp_err);
        end
        checks++;
        if (rdy !== exp_rdy) begin errors++; $display("FAIL %s_in_ready_after: got %b required %b", name, rdy, exp_rdy); end
        checks++;
        if (sb.pred_class !== exp_pc) begin errors++; $display("FAIL %s_hold: pred_class=%0d required %0d", name, sb.pred_class, exp_pc); end
    endtask

    task automatic test_basic();
        test_sample("basic", 32'sd10, 32'sd50, -32'sd3, 32'sd7, 4'd1, 2'd1, 1'b1, 1, 0, 1'b1);
    endtask

    task automatic test_tie();
        test_sample("tie", 32'sd5, 32'sd5, 32'sd5, 32'sd5, 4'd2, 2'd0, 1'b0, 2, 1, 1'b1);
    endtask

    task automatic test_signed();
        logic [15:0] exp_cell;
`ifdef CLASSIFY_CONFUSION_EN
        exp_cell = 16'd1;
`else
        exp_cell = 16'd0;
`endif
        test_sample("signed", -32'sd100, -32'sd1, -32'sd50, -32'sd2, 4'd3, 2'd1, 1'b0, 3, 2, 1'b1);
        sb.cm_rd_addr = 4'h5;
        #1;
        checks++;
        if (sb.cm_rd_data !== exp_cell) begin errors++; $display("FAIL cm_cell5: got %0d required %0d", sb.cm_rd_data, exp_cell); end
        sb.cm_rd_addr = 4'hD;
        #1;
        checks++;
        if (sb.cm_rd_data !== exp_cell) begin errors++; $display("FAIL cm_cellD: got %0d required %0d", sb.cm_rd_data, exp_cell); end
    endtask

    // Fourth back-to-back sample with an out-of-range label completes the run.
    task automatic test_back_to_back();
        test_sample("badlabel", 32'sd1, 32'sd2, 32'sd3, 32'sd4, 4'd4, 2'd3, 1'b0, 4, 3, 1'b0);
        checks++;
        if (sb.done !== 1'b1) begin errors++; $display("FAIL done_set: got %b required 1", sb.done); end
        sb.cm_rd_addr = 4'h3;
        #1;
        checks++;
        if (sb.cm_rd_data !== 16'd0) begin errors++; $display("FAIL cm_badlabel: got %0d required 0", sb.cm_rd_data); end
    endtask

    task automatic test_done_hold();
        int pulses, first_at;
        logic [1:0] pc;
        logic cor, rdy;
        @(negedge clk);
        sb.act_n0   = 32'sd9;
        sb.label    = 4'd0;
        sb.in_valid = 1'b1;
        observe(8, pulses, first_at, pc, cor, rdy);
        sb.in_valid = 1'b0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL done_ignore_pulses: got %0d required 0", pulses); end
        checks++;
        if (sb.sample_count !== 32'd4 || sb.done !== 1'b1 || rdy !== 1'b0) begin
            errors++; $display("FAIL done_hold: count=%0d done=%b in_ready=%b required 4/1/0", sb.sample_count, sb.done, rdy);
        end
        sb.clear = 1'b1;
        @(posedge clk);
        #1;
        sb.clear = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.sample_count !== 32'd0 || sb.error_counter !== 32'd0) begin
            errors++; $display("FAIL clear_counters: count=%0d err=%0d required 0/0", sb.sample_count, sb.error_counter);
        end
        checks++;
        if (sb.done !== 1'b0 || sb.in_ready !== 1'b1) begin
            errors++; $display("FAIL clear_state: done=%b in_ready=%b required 0/1", sb.done, sb.in_ready);
        end
        sb.cm_rd_addr = 4'h5;
        #1;
        checks++;
        if (sb.cm_rd_data !== 16'd0) begin errors++; $display("FAIL clear_cm: got %0d required 0", sb.cm_rd_data); end
    endtask

    task automatic test_clear_abort();
        int pulses, first_at;
        logic [1:0] pc;
        logic cor, rdy;
        send(32'sd1, 32'sd2, 32'sd3, 32'sd4, 4'd3);
        @(negedge clk);
        sb.clear = 1'b1;
        @(posedge clk);
        #1;
        sb.clear = 1'b0;
        observe(6, pulses, first_at, pc, cor, rdy);
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_pulses: got %0d required 0", pulses); end
        checks++;
        if (sb.sample_count !== 32'd0 || rdy !== 1'b1) begin
            errors++; $display("FAIL abort_state: count=%0d in_ready=%b required 0/1", sb.sample_count, rdy);
        end
    endtask

    task automatic test_clear_with_valid();
        int pulses, first_at;
        logic [1:0] pc;
        logic cor, rdy;
        sb.act_n0   = 32'sd7;
        sb.label    = 4'd0;
        sb.clear    = 1'b1;
        sb.in_valid = 1'b1;
        #1;
        checks++;
        if (sb.in_ready !== 1'b0) begin errors++; $display("FAIL clear_valid_ready: got %b required 0", sb.in_ready); end
        @(posedge clk);
        #1;
        sb.clear    = 1'b0;
        sb.in_valid = 1'b0;
        observe(6, pulses, first_at, pc, cor, rdy);
        checks++;
        if (pulses != 0 || sb.sample_count !== 32'd0) begin
            errors++; $display("FAIL clear_valid_accept: pulses=%0d count=%0d required 0/0", pulses, sb.sample_count);
        end
    endtask

    task automatic test_confusion();
        logic [15:0] exp_c;
`ifdef CLASSIFY_CONFUSION_EN
        exp_c = 16'd2;
`else
        exp_c = 16'd0;
`endif
        test_sample("cm1", 32'sd100, 32'sd1, 32'sd2, 32'sd3, 4'd3, 2'd0, 1'b0, 1, 1, 1'b1);
        test_sample("cm2", 32'sd100, 32'sd1, 32'sd2, 32'sd3, 4'd3, 2'd0, 1'b0, 2, 2, 1'b1);
        sb.cm_rd_addr = 4'hC;
        #1;
        checks++;
        if (sb.cm_rd_data !== exp_c) begin errors++; $display("FAIL cm_cellC: got %0d required %0d", sb.cm_rd_data, exp_c); end
        sb.cm_rd_addr = 4'h0;
        #1;
        checks++;
        if (sb.cm_rd_data !== 16'd0) begin errors++; $display("FAIL cm_cell0: got %0d required 0", sb.cm_rd_data); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_tie();
        test_signed();
        test_back_to_back();
        test_done_hold();
        test_clear_abort();
        test_clear_with_valid();
        test_confusion();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
